i2c_clknrst_seq: RTL and testbench
==================================

# i2c_clknrst_seq

Synchronous sequencer that brings up an I2C block: it holds a downstream reset for a programmable number of cycles, waits a short settle window, then runs a programmable-divider SCL generator (half-period tick plus SCL level). It stops cleanly with SCL parked high. It sits between the system clock/reset and the I2C master datapath, and is the single owner of the datapath's reset and SCL timing.

## Interface
Parameters:
- DIV_W, 16, width of the half-period divider value.
- RSTLEN_W, 8, width of the reset-length value.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse; begin the bring-up sequence.
- stop_i  in  1  single-cycle pulse; park SCL high and go OFF.
- rst_req_i  in  1  single-cycle pulse; re-run the reset phase while running.
- div_i  in  DIV_W  SCL half-period in clk cycles; sampled on accepted start_i.
- rst_len_i  in  RSTLEN_W  reset hold length in clk cycles; sampled on accepted start_i or rst_req_i.
- stretch_i  in  1  SCL line observed low (slave stretch); only present with the macro defined.
- rst_o  out  1  active-high reset to the datapath.
- tick_o  out  1  one-cycle pulse at every SCL edge.
- scl_o  out  1  SCL level (1 = released).
- running_o  out  1  high in RUN.
- busy_o  out  1  high in every state except OFF.

## Operation
- States: OFF, RST, SETTLE, RUN, DRAIN.
- OFF:
  - rst_o=1, scl_o=1.
  - start_i moves to RST; div_i and rst_len_i are latched.
  - Latched divider D = max(div_i, 2). Latched length L = max(rst_len_i, 1).
- RST:
  - rst_o=1 and scl_o=1.
  - Down-counter runs from L; leave to SETTLE after L cycles.
- SETTLE: rst_o=0; fixed 2 cycles, then RUN.
- RUN:
  - Divider counter counts 0..D-1.
  - At count D-1: counter returns to 0, tick_o pulses for one cycle and scl_o toggles.
- stop_i in RUN:
  - If scl_o=1, go straight to OFF with no further tick.
  - If scl_o=0, go to DRAIN.
- DRAIN: divider keeps counting; at the next tick scl_o goes 1, then OFF.
- rst_req_i in RUN or DRAIN:
  - Go to RST and re-latch rst_len_i.
  - scl_o is forced 1, the divider is cleared and D is kept.
- Priority within one cycle: reset > stop_i > rst_req_i > start_i.
- start_i outside OFF is ignored. stop_i in RST or SETTLE goes directly to OFF.
- Divider and length counters saturate and never wrap. Arithmetic is unsigned at DIV_W / RSTLEN_W.

## Timing
- Reset values (while reset=1 and the cycle after): state OFF, rst_o=1, tick_o=0, scl_o=1, running_o=0, busy_o=0, all counters 0.
- start_i high at cycle 0:
  - busy_o=1 from cycle 1.
  - rst_o stays 1 through cycle L and drops at cycle L+1.
  - running_o=1 from cycle L+3.
  - First tick_o (scl_o 1->0) at cycle L+3+D-1.
- SCL period is exactly 2D cycles with 50% duty, not counting stretch.
- tick_o and the scl_o change are registered in the same cycle.
- stop_i with scl_o=1: OFF and busy_o=0 on the next cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: I2C_CLKNRST_SEQ_STRETCH_EN.
- Defined:
  - stretch_i port exists.
  - In RUN or DRAIN, while scl_o=1 and stretch_i=1, the divider counter holds its value.
  - The high half-period restarts counting from 0 on the first cycle stretch_i is low.
  - The low half is never affected.
- Undefined: stretch_i is absent; the divider always free-runs.

## Structure
- Package i2c_clknrst_seq_pkg:
  - state enum (OFF, RST, SETTLE, RUN, DRAIN).
  - localparams SETTLE_CYCLES=2 and MIN_DIV=2.
  - clamp functions for D and L.
- One sub-module, i2c_clknrst_seq_div: the divider counter with hold and clear inputs, and tick and scl outputs.
- The top level holds the FSM and the reset-length counter.

## Test plan
- Reset then start_i with div_i=5, rst_len_i=3 -> rst_o high through cycle 3 and low at cycle 4; running_o at cycle 6; first tick at cycle 10; scl period 10 cycles.
- div_i=0, rst_len_i=0 -> D=2, L=1; scl toggles every 2 cycles; rst_o drops at cycle 2.
- stop_i while scl_o=0 (D=4) -> DRAIN, exactly one more tick, scl_o=1, then OFF with busy_o=0; stop_i while scl_o=1 -> OFF next cycle with no tick.
- rst_req_i mid-RUN with rst_len_i=6 -> scl_o=1 immediately, rst_o high for 6 cycles, then SETTLE, RUN, first tick D cycles later.
- start_i and stop_i in the same cycle in OFF -> stays OFF; reset asserted in RUN -> all outputs at reset values on the next cycle.
- With I2C_CLKNRST_SEQ_STRETCH_EN defined, D=4, stretch_i=1 for 7 cycles during the high phase -> high phase lasts 4 cycles after stretch_i falls; low phase unchanged at 4.

Source files
------------

// File: rtl/i2c_clknrst_seq_pkg.sv
// ============================================================================
// i2c_clknrst_seq_pkg : shared state encoding, timing constants and clamps
// Revision: 1.0
// ============================================================================
`default_nettype none

package i2c_clknrst_seq_pkg;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        RST    = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_e;

    localparam int SETTLE_CYCLES = 2;
    localparam int MIN_DIV       = 2;
    localparam int MIN_LEN       = 1;

    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
    endfunction

    function automatic logic [31:0] clamp_len(input logic [31:0] v);
        return (v < 32'(MIN_LEN)) ? 32'(MIN_LEN) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_clknrst_seq_div.sv
// ============================================================================
// i2c_clknrst_seq_div : SCL half-period divider with hold/clear, registered
//                       tick and SCL level
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_clknrst_seq_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             hold_i,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             scl_o
);
    import i2c_clknrst_seq_pkg::*;

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] w_eff_cnt;
    logic             tick_q;
    logic             scl_q;
    logic             stretched_q;
    logic             w_wrap;

    // After a stretch the high half restarts, so the first free cycle counts as 0.
    always_comb begin
        w_eff_cnt = stretched_q ? '0 : cnt_q;
        w_wrap    = en_i && !hold_i && (w_eff_cnt == (div_i - DIV_W'(1)));
        if (w_wrap) begin
            cnt_d = '0;
        end else if (w_eff_cnt == '1) begin
            cnt_d = w_eff_cnt;
        end else begin
            cnt_d = w_eff_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            scl_q       <= 1'b1;
            stretched_q <= 1'b0;
        end else begin
            tick_q <= w_wrap;
            if (w_wrap) begin
                scl_q <= ~scl_q;
            end
            if (en_i) begin
                if (hold_i) begin
                    stretched_q <= 1'b1;
                end else begin
                    stretched_q <= 1'b0;
                    cnt_q       <= cnt_d;
                end
            end
        end
    end

    assign tick_o = tick_q;
    assign scl_o  = scl_q;

endmodule

`default_nettype wire

// File: rtl/i2c_clknrst_seq.sv
// ============================================================================
// i2c_clknrst_seq : reset/settle/SCL bring-up sequencer for an I2C datapath.
// Optional clock stretching: define I2C_CLKNRST_SEQ_STRETCH_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_clknrst_seq
    import i2c_clknrst_seq_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int RSTLEN_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                rst_req_i,
    input  logic [DIV_W-1:0]    div_i,
    input  logic [RSTLEN_W-1:0] rst_len_i,
`ifdef I2C_CLKNRST_SEQ_STRETCH_EN
    input  logic                stretch_i,
`endif
    output logic                rst_o,
    output logic                tick_o,
    output logic                scl_o,
    output logic                running_o,
    output logic                busy_o
);

    state_e              state_q;
    state_e              state_d;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_d;
    logic [RSTLEN_W-1:0] len_q;
    logic [RSTLEN_W-1:0] len_d;
    logic                rst_q;
    logic                running_q;
    logic                busy_q;

    logic                w_scl;
    logic                w_div_en;
    logic                w_div_clr;
    logic                w_hold;
    logic                w_len_last;
    logic [DIV_W-1:0]    w_div_clamped;
    logic [RSTLEN_W-1:0] w_len_clamped;

    assign w_div_clamped = DIV_W'(clamp_div(32'(div_i)));
    assign w_len_clamped = RSTLEN_W'(clamp_len(32'(rst_len_i)));
    assign w_len_last    = (len_q == '0) || (len_q == RSTLEN_W'(1));

`ifdef I2C_CLKNRST_SEQ_STRETCH_EN
    assign w_hold = stretch_i && w_scl && ((state_q == RUN) || (state_q == DRAIN));
`else
    assign w_hold = 1'b0;
`endif

    // The length counter is shared: reset hold in RST, settle window in SETTLE.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        len_d    = len_q;
        w_div_en = 1'b0;
        case (state_q)
            OFF: begin
                if (!stop_i && start_i) begin
                    state_d = RST;
                    div_d   = w_div_clamped;
                    len_d   = w_len_clamped;
                end
            end
            RST: begin
                if (stop_i) begin
                    state_d = OFF;
                end else if (w_len_last) begin
                    state_d = SETTLE;
                    len_d   = RSTLEN_W'(SETTLE_CYCLES);
                end else begin
                    len_d = len_q - RSTLEN_W'(1);
                end
            end
            SETTLE: begin
                if (stop_i) begin
                    state_d = OFF;
                end else if (w_len_last) begin
                    state_d  = RUN;
                    len_d    = '0;
                    w_div_en = 1'b1;
                end else begin
                    len_d = len_q - RSTLEN_W'(1);
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d  = w_scl ? OFF : DRAIN;
                    w_div_en = !w_scl;
                end else if (rst_req_i) begin
                    state_d = RST;
                    len_d   = w_len_clamped;
                end else begin
                    w_div_en = 1'b1;
                end
            end
            DRAIN: begin
                if (rst_req_i) begin
                    state_d = RST;
                    len_d   = w_len_clamped;
                end else if (w_scl) begin
                    state_d = OFF;
                end else begin
                    w_div_en = 1'b1;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
        if (state_d == OFF) begin
            len_d = '0;
        end
    end

    // Entering OFF or RST parks SCL high and empties the divider.
    assign w_div_clr = (state_d == OFF) || (state_d == RST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OFF;
            div_q     <= DIV_W'(MIN_DIV);
            len_q     <= '0;
            rst_q     <= 1'b1;
            running_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            len_q     <= len_d;
            rst_q     <= (state_d == OFF) || (state_d == RST);
            running_q <= (state_d == RUN);
            busy_q    <= (state_d != OFF);
        end
    end

    i2c_clknrst_seq_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .en_i    (w_div_en),
        .hold_i  (w_hold),
        .clear_i (w_div_clr),
        .div_i   (div_q),
        .tick_o  (tick_o),
        .scl_o   (w_scl)
    );

    assign scl_o     = w_scl;
    assign rst_o     = rst_q;
    assign running_o = running_q;
    assign busy_o    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_clknrst_seq.sv
// ============================================================================
// tb_i2c_clknrst_seq : directed self-checking bench for i2c_clknrst_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_i2c_clknrst_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        stop_i;
    logic        rst_req_i;
    logic [15:0] div_i;
    logic [7:0]  rst_len_i;
    logic        stretch_i;
    logic        rst_o;
    logic        tick_o;
    logic        scl_o;
    logic        running_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n        = 0;

    always #5 clk = ~clk;

    i2c_clknrst_seq #(
        .DIV_W    (16),
        .RSTLEN_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .rst_req_i (rst_req_i),
        .div_i     (div_i),
        .rst_len_i (rst_len_i),
`ifdef I2C_CLKNRST_SEQ_STRETCH_EN
        .stretch_i (stretch_i),
`endif
        .rst_o     (rst_o),
        .tick_o    (tick_o),
        .scl_o     (scl_o),
        .running_o (running_o),
        .busy_o    (busy_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // exp bit order: {rst_o, tick_o, scl_o, running_o, busy_o}
    task automatic chk_o(input string tag, input logic [4:0] exp);
        chk(tag, {27'b0, rst_o, tick_o, scl_o, running_o, busy_o}, {27'b0, exp});
    endtask

    task automatic count_ticks(input int cycles);
        n = 0;
        repeat (cycles) begin
            step();
            n += int'(tick_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_i = 1'b0; stop_i = 1'b0; rst_req_i = 1'b0;
        div_i = '0; rst_len_i = '0; stretch_i = 1'b0;
        repeat (3) step();
        chk_o("reset_hold", 5'b10100);
        reset = 1'b0;
        step();
        chk_o("reset_after", 5'b10100);

        // D=5, L=3
        div_i = 16'd5; rst_len_i = 8'd3; start_i = 1'b1; cyc = 0;
        step();
        start_i = 1'b0; div_i = '0; rst_len_i = '0;
        chk_o("t1_c1_busy", 5'b10101);
        run_to(3);  chk_o("t1_c3_rst_high", 5'b10101);
        run_to(4);  chk_o("t1_c4_rst_low", 5'b00101);
        run_to(5);  chk_o("t1_c5_settle", 5'b00101);
        run_to(6);  chk_o("t1_c6_running", 5'b00111);
        run_to(9);  chk_o("t1_c9_no_tick", 5'b00111);
        run_to(10); chk_o("t1_first_tick", 5'b01011);
        count_ticks(4);
        chk("t1_low_quiet", n, 0);
        run_to(15); chk_o("t1_second_tick", 5'b01111);
        run_to(16);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk_o("t1_stop_scl_high", 5'b10100);

        // D=2, L=1 via zero inputs; then rst_req with new length
        div_i = '0; rst_len_i = '0; start_i = 1'b1; cyc = 0;
        step();
        start_i = 1'b0;
        chk_o("t2_c1", 5'b10101);
        run_to(2);  chk_o("t2_rst_drop", 5'b00101);
        run_to(4);  chk_o("t2_running", 5'b00111);
        run_to(5);  chk_o("t2_tick_low", 5'b01011);
        run_to(6);  chk_o("t2_c6", 5'b00011);
        rst_req_i = 1'b1; rst_len_i = 8'd6; div_i = 16'd9;
        step();
        rst_req_i = 1'b0; div_i = '0;
        chk_o("t2_rstreq_scl_high", 5'b10101);
        run_to(12); chk_o("t2_rst_c12", 5'b10101);
        run_to(13); chk_o("t2_rst_drop", 5'b00101);
        run_to(14); chk_o("t2_settle", 5'b00101);
        run_to(15); chk_o("t2_rerun", 5'b00111);
        run_to(16); chk_o("t2_tick_keep_d", 5'b01011);
        reset = 1'b1;
        step();
        chk_o("t2_reset_in_run", 5'b10100);
        reset = 1'b0;
        step();
        chk_o("t2_reset_after", 5'b10100);

        // D=4, L=2: stop while SCL low drains one tick
        div_i = 16'd4; rst_len_i = 8'd2; start_i = 1'b1; cyc = 0;
        step();
        start_i = 1'b0;
        run_to(8);  chk_o("t3_first_tick", 5'b01011);
        run_to(9);  chk_o("t3_c9", 5'b00011);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk_o("t3_drain", 5'b00001);
        run_to(11); chk_o("t3_drain_c11", 5'b00001);
        run_to(12); chk_o("t3_drain_tick", 5'b01101);
        run_to(13); chk_o("t3_off", 5'b10100);
        count_ticks(10);
        chk("t3_no_more_ticks", n, 0);

        // start and stop together in OFF; stop during RST
        start_i = 1'b1; stop_i = 1'b1;
        step();
        start_i = 1'b0; stop_i = 1'b0;
        chk_o("t4_start_stop_off", 5'b10100);
        step();
        chk_o("t4_still_off", 5'b10100);
        div_i = 16'd3; rst_len_i = 8'd4; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk_o("t4_in_rst", 5'b10101);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk_o("t4_stop_in_rst", 5'b10100);

`ifdef I2C_CLKNRST_SEQ_STRETCH_EN
        // D=4, L=1: stretch during high half
        div_i = 16'd4; rst_len_i = 8'd1; start_i = 1'b1; cyc = 0;
        step();
        start_i = 1'b0;
        run_to(7);  chk_o("t5_tick_low", 5'b01011);
        run_to(11); chk_o("t5_tick_high", 5'b01111);
        run_to(12);
        stretch_i = 1'b1;
        count_ticks(7);
        stretch_i = 1'b0;
        chk("t5_stretch_no_tick", n, 0);
        count_ticks(3);
        chk("t5_high_after_fall", n, 0);
        chk_o("t5_c22_high", 5'b00111);
        run_to(23); chk_o("t5_tick_after_stretch", 5'b01011);
        count_ticks(3);
        chk("t5_low_quiet", n, 0);
        run_to(27); chk_o("t5_low_len4", 5'b01111);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
